// File: rtl/lsu_initiator.sv
// Load/store initiator: turns byte/half/word CPU requests into word-wide memory accesses.
// Define LSU_INITIATOR_MISALIGNED_EN to split misaligned accesses over two words; otherwise they error.
module lsu_initiator (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [29:0] daddr,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  input  logic [31:0] rdata
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // ACC1  | access to the word holding the first byte
  // ACC2  | access to the following word (split accesses only)
  // RESP  | one-cycle response pulse
  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

`ifdef LSU_INITIATOR_MISALIGNED_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  state_t      state, state_nxt;
  logic        r_we, r_uns;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, lo_q;

  logic [1:0]  off;
  logic [29:0] base;
  logic        mis, err;
  logic [3:0]  size_mask;
  logic [7:0]  m64;
  logic [63:0] d64;
  logic [63:0] ld_cat;
  logic [31:0] ld_sh, ld_ext, rsp_d;

  assign off  = r_addr[1:0];
  assign base = r_addr[31:2];
  assign mis  = (r_size == 2'd1 && off == 2'd3) || (r_size == 2'd2 && off != 2'd0);
  assign err  = (r_size == 2'd3) || (mis && !MIS_EN);

  always_comb begin
    size_mask = 4'b0000;
    case (r_size)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      2'd2:    size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  end

  assign m64 = {4'b0000, size_mask} << off;
  assign d64 = {32'b0, r_wdata} << {off, 3'b000};

  // Low word is captured in ACC1; in ACC2 the live rdata is the high word.
  assign ld_cat = (state == ACC2) ? {rdata, lo_q} : {32'b0, rdata};
  assign ld_sh  = ld_cat[{off, 3'b000} +: 32];

  always_comb begin
    ld_ext = ld_sh;
    case (r_size)
      2'd0:    ld_ext = r_uns ? {24'b0, ld_sh[7:0]}  : {{24{ld_sh[7]}}, ld_sh[7:0]};
      2'd1:    ld_ext = r_uns ? {16'b0, ld_sh[15:0]} : {{16{ld_sh[15]}}, ld_sh[15:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  assign rsp_d = (r_we || err) ? 32'b0 : ld_ext;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      r_we      <= 1'b0;
      r_uns     <= 1'b0;
      r_size    <= 2'd0;
      r_addr    <= 32'b0;
      r_wdata   <= 32'b0;
      lo_q      <= 32'b0;
      rsp_rdata <= 32'b0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        r_we    <= req_we;
        r_uns   <= req_unsigned;
        r_size  <= req_size;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (state == ACC1) lo_q <= rdata;
      // Response fields only change on entry to RESP so they hold afterwards.
      if (state_nxt == RESP && state != RESP) begin
        rsp_rdata <= rsp_d;
        rsp_err   <= err;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    daddr     = 30'b0;
    wmask     = 4'b0000;
    wdata     = 32'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ACC1;
      end
      ACC1: begin
        daddr = base;
        if (!err && r_we) begin
          wmask = m64[3:0];
          wdata = d64[31:0];
        end
        state_nxt = (mis && !err) ? ACC2 : RESP;
      end
      ACC2: begin
        daddr = base + 30'd1;
        if (r_we) begin
          wmask = m64[7:4];
          wdata = d64[63:32];
        end
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
